// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, forward selects,
// branch funct3 codes and the multiplier FSM states.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_RESULTW = 2'b01,
    FWD_ALUM    = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Busy covers the start cycle plus WIDTH RUN cycles; done flags the result cycle.
module seq_multiplier
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);
  localparam int CW = $clog2(WIDTH);

  mul_state_t       r_state;
  mul_state_t       w_state_next;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             w_last;

  assign w_last = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MUL_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MUL_IDLE: if (i_start) w_state_next = MUL_RUN;
      MUL_RUN:  if (w_last)  w_state_next = MUL_DONE;
      MUL_DONE: w_state_next = MUL_IDLE;
      default:  w_state_next = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (r_state == MUL_IDLE) begin
      if (i_start) begin
        r_mcand  <= i_a;
        r_mplier <= i_b;
        r_acc    <= '0;
        r_count  <= '0;
      end
    end else if (r_state == MUL_RUN) begin
      // Multiplicand shifts left as the multiplier shifts right; upper bits fall off.
      r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  end

  assign o_busy    = ((r_state == MUL_IDLE) && i_start) || (r_state == MUL_RUN);
  assign o_done    = (r_state == MUL_DONE);
  assign o_product = r_acc;

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: ID/EX register, forwarding, ALU, branch resolution.
// Define EXEC_MUL_EN to add the iterative multiplier and its BusyE stall.
module execute_stage
  import exec_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallD,
  input  logic              FlushE,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic              JALRctrlD,
  input  logic              MulD,
  input  logic [1:0]        ResultSrcD,
  input  logic [3:0]        ALUControlD,
  input  logic [2:0]        Funct3D,
  input  logic [WIDTH-1:0]  RD1D,
  input  logic [WIDTH-1:0]  RD2D,
  input  logic [WIDTH-1:0]  PCD,
  input  logic [WIDTH-1:0]  ImmExtD,
  input  logic [WIDTH-1:0]  PCPlus4D,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [WIDTH-1:0]  ResultW,
  input  logic [WIDTH-1:0]  ALUResultM,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              PCSrcE,
  output logic              BusyE,
  output logic [1:0]        ResultSrcE,
  output logic [WIDTH-1:0]  ALUResultE,
  output logic [WIDTH-1:0]  WriteDataE,
  output logic [WIDTH-1:0]  PCTargetE,
  output logic [WIDTH-1:0]  PCPlus4E,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] LSB_CLEAR = {{(WIDTH-1){1'b1}}, 1'b0};

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              jump;
    logic              branch;
    logic              alu_src;
    logic              jalr;
`ifdef EXEC_MUL_EN
    logic              mul;
`endif
    logic [1:0]        result_src;
    logic [3:0]        alu_control;
    logic [2:0]        funct3;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  imm;
    logic [WIDTH-1:0]  pc_plus4;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } idex_t;

  idex_t            r_idex;
  idex_t            w_idex_d;
  logic             w_busy;
  logic [WIDTH-1:0] w_src_a;
  logic [WIDTH-1:0] w_src_b;
  logic [WIDTH-1:0] w_write_data;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_cond;

  always_comb begin
    w_idex_d             = '0;
    w_idex_d.reg_write   = RegWriteD;
    w_idex_d.mem_write   = MemWriteD;
    w_idex_d.jump        = JumpD;
    w_idex_d.branch      = BranchD;
    w_idex_d.alu_src     = ALUSrcD;
    w_idex_d.jalr        = JALRctrlD;
`ifdef EXEC_MUL_EN
    w_idex_d.mul         = MulD;
`endif
    w_idex_d.result_src  = ResultSrcD;
    w_idex_d.alu_control = ALUControlD;
    w_idex_d.funct3      = Funct3D;
    w_idex_d.rd1         = RD1D;
    w_idex_d.rd2         = RD2D;
    w_idex_d.pc          = PCD;
    w_idex_d.imm         = ImmExtD;
    w_idex_d.pc_plus4    = PCPlus4D;
    w_idex_d.rs1         = Rs1D;
    w_idex_d.rs2         = Rs2D;
    w_idex_d.rd          = RdD;
  end

  // A running multiply owns the register, so it beats flush and stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_idex <= '0;
    else if (w_busy) r_idex <= r_idex;
    else if (FlushE) r_idex <= '0;
    else if (!StallD) r_idex <= w_idex_d;
  end

  always_comb begin
    case (ForwardAE)
      FWD_RESULTW: w_src_a = ResultW;
      FWD_ALUM:    w_src_a = ALUResultM;
      default:     w_src_a = r_idex.rd1;
    endcase
    case (ForwardBE)
      FWD_RESULTW: w_write_data = ResultW;
      FWD_ALUM:    w_write_data = ALUResultM;
      default:     w_write_data = r_idex.rd2;
    endcase
  end

  assign w_src_b = r_idex.alu_src ? r_idex.imm : w_write_data;
  assign w_shamt = w_src_b[SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (r_idex.alu_control)
      ALU_ADD:   w_alu = w_src_a + w_src_b;
      ALU_SUB:   w_alu = w_src_a - w_src_b;
      ALU_AND:   w_alu = w_src_a & w_src_b;
      ALU_OR:    w_alu = w_src_a | w_src_b;
      ALU_XOR:   w_alu = w_src_a ^ w_src_b;
      ALU_SLT:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
      ALU_SLTU:  w_alu = {{(WIDTH-1){1'b0}}, (w_src_a < w_src_b)};
      ALU_SLL:   w_alu = w_src_a << w_shamt;
      ALU_SRL:   w_alu = w_src_a >> w_shamt;
      ALU_SRA:   w_alu = $unsigned($signed(w_src_a) >>> w_shamt);
      ALU_PASSB: w_alu = w_src_b;
      default:   w_alu = '0;
    endcase
  end

  // Branches compare rs2 as forwarded, never the immediate.
  always_comb begin
    w_cond = 1'b0;
    case (r_idex.funct3)
      F3_BEQ:  w_cond = (w_src_a == w_write_data);
      F3_BNE:  w_cond = (w_src_a != w_write_data);
      F3_BLT:  w_cond = ($signed(w_src_a) <  $signed(w_write_data));
      F3_BGE:  w_cond = ($signed(w_src_a) >= $signed(w_write_data));
      F3_BLTU: w_cond = (w_src_a <  w_write_data);
      F3_BGEU: w_cond = (w_src_a >= w_write_data);
      default: w_cond = 1'b0;
    endcase
  end

`ifdef EXEC_MUL_EN
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;

  seq_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (r_idex.mul),
    .i_a       (w_src_a),
    .i_b       (w_src_b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  assign w_busy       = w_mul_busy;
  assign w_alu_result = w_mul_done ? w_mul_product : w_alu;
`else
  logic w_unused_mul;
  assign w_unused_mul = MulD;
  assign w_busy       = 1'b0;
  assign w_alu_result = w_alu;
`endif

  assign RegWriteE  = r_idex.reg_write & ~w_busy;
  assign MemWriteE  = r_idex.mem_write & ~w_busy;
  assign PCSrcE     = (r_idex.jump | (r_idex.branch & w_cond)) & ~w_busy;
  assign BusyE      = w_busy;
  assign ResultSrcE = r_idex.result_src;
  assign ALUResultE = w_alu_result;
  assign WriteDataE = w_write_data;
  assign PCTargetE  = r_idex.jalr ? (w_alu_result & LSB_CLEAR) : (r_idex.pc + r_idex.imm);
  assign PCPlus4E   = r_idex.pc_plus4;
  assign Rs1E       = r_idex.rs1;
  assign Rs2E       = r_idex.rs2;
  assign RdE        = r_idex.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Randomised scoreboard bench for execute_stage; multiply tests only when
// EXEC_MUL_EN is defined.
module tb_execute_stage;
  localparam int WIDTH  = 32;
  localparam int REG_AW = 5;
`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk, rst, StallD, FlushE;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD, MulD;
  logic [1:0] ResultSrcD, ForwardAE, ForwardBE;
  logic [3:0] ALUControlD;
  logic [2:0] Funct3D;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D, ResultW, ALUResultM;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic RegWriteE, MemWriteE, PCSrcE, BusyE;
  logic [1:0] ResultSrcE;
  logic [31:0] ALUResultE, WriteDataE, PCTargetE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;

  execute_stage #(.WIDTH(WIDTH), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .StallD(StallD), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .JALRctrlD(JALRctrlD), .MulD(MulD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .Funct3D(Funct3D), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW), .ALUResultM(ALUResultM),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE), .BusyE(BusyE),
    .ResultSrcE(ResultSrcE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic regw, memw, jump, branch, alusrc, jalr, mul;
    logic [1:0] rsrc; logic [3:0] aluc; logic [2:0] f3;
    logic [31:0] rd1, rd2, pc, imm, pcp4;
    logic [4:0] rs1, rs2, rd;
  } instr_t;

  typedef struct packed {
    instr_t d; logic flush, stall; logic [1:0] fa, fb; logic [31:0] resw, alum;
  } stim_t;

  typedef struct packed {
    logic regw, memw, pcsrc, busy; logic [1:0] rsrc;
    logic [31:0] alu, wd, pct, pcp4; logic [4:0] rs1, rs2, rd;
  } exp_t;

  exp_t   sb[$];
  instr_t ex_m;        // what the ID/EX register should hold
  stim_t  cur_stim;
  bit     cur_busy;
  bit     mul_started;
  int     mul_left;
  logic [31:0] mul_prod;
  int     n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r, w, m);
    if (s == 2'b01) return w;
    if (s == 2'b10) return m;
    return r;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, b);
    int sa = a;
    int sb_ = b;
    int sh = int'(b % 32);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sa < sb_) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << sh;
      4'd8: return a >> sh;
      4'd9: return sa >>> sh;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit br_ref(input logic [2:0] f3, input logic [31:0] a, b);
    int sa = a;
    int sb_ = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb_;
      3'd5: return sa >= sb_;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s = '0;
    s.d.regw = 1'($urandom); s.d.memw = 1'($urandom); s.d.jump = 1'($urandom);
    s.d.branch = 1'($urandom); s.d.alusrc = 1'($urandom); s.d.jalr = 1'($urandom);
    s.d.mul = MUL_EN ? 1'b0 : 1'($urandom);
    s.d.rsrc = 2'($urandom); s.d.aluc = 4'($urandom); s.d.f3 = 3'($urandom);
    s.d.rd1 = pick32(); s.d.rd2 = pick32(); s.d.pc = $urandom; s.d.imm = pick32();
    s.d.pcp4 = $urandom; s.d.rs1 = 5'($urandom); s.d.rs2 = 5'($urandom); s.d.rd = 5'($urandom);
    s.flush = ($urandom_range(0, 9) == 0);
    s.stall = ($urandom_range(0, 6) == 0);
    s.fa = 2'($urandom); s.fb = 2'($urandom); s.resw = pick32(); s.alum = pick32();
    return s;
  endfunction

  // Apply one cycle of inputs and queue the response the model predicts for it.
  task automatic drive(input stim_t s);
    exp_t e;
    logic [31:0] a, wd, b, alu;
    logic [63:0] p;
    bit busy = 1'b0;
    {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD, MulD} =
      {s.d.regw, s.d.memw, s.d.jump, s.d.branch, s.d.alusrc, s.d.jalr, s.d.mul};
    ResultSrcD = s.d.rsrc; ALUControlD = s.d.aluc; Funct3D = s.d.f3;
    RD1D = s.d.rd1; RD2D = s.d.rd2; PCD = s.d.pc; ImmExtD = s.d.imm; PCPlus4D = s.d.pcp4;
    Rs1D = s.d.rs1; Rs2D = s.d.rs2; RdD = s.d.rd;
    FlushE = s.flush; StallD = s.stall;
    ForwardAE = s.fa; ForwardBE = s.fb; ResultW = s.resw; ALUResultM = s.alum;
    a   = fwd(s.fa, ex_m.rd1, s.resw, s.alum);
    wd  = fwd(s.fb, ex_m.rd2, s.resw, s.alum);
    b   = ex_m.alusrc ? ex_m.imm : wd;
    alu = alu_ref(ex_m.aluc, a, b);
    if (MUL_EN && ex_m.mul) begin
      if (!mul_started) begin
        mul_started = 1'b1; mul_left = WIDTH; busy = 1'b1;
        p = 64'(a) * 64'(b); mul_prod = p[31:0];
      end else if (mul_left > 0) begin
        mul_left--; busy = 1'b1;
      end else begin
        alu = mul_prod; mul_started = 1'b0;
      end
    end
    e.busy  = busy;
    e.regw  = ex_m.regw & !busy;
    e.memw  = ex_m.memw & !busy;
    e.pcsrc = (ex_m.jump | (ex_m.branch & br_ref(ex_m.f3, a, wd))) & !busy;
    e.rsrc  = ex_m.rsrc; e.alu = alu; e.wd = wd;
    e.pct   = ex_m.jalr ? (alu & 32'hFFFF_FFFE) : (ex_m.pc + ex_m.imm);
    e.pcp4  = ex_m.pcp4; e.rs1 = ex_m.rs1; e.rs2 = ex_m.rs2; e.rd = ex_m.rd;
    sb.push_back(e);
    cur_busy = busy;
    cur_stim = s;
  endtask

  task automatic step();
    @(posedge clk);
    if (!cur_busy) begin
      if (cur_stim.flush)      ex_m = '0;
      else if (!cur_stim.stall) ex_m = cur_stim.d;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("RegWriteE", RegWriteE, e.regw);
      check("MemWriteE", MemWriteE, e.memw);
      check("PCSrcE", PCSrcE, e.pcsrc);
      check("BusyE", BusyE, e.busy);
      check("ResultSrcE", ResultSrcE, e.rsrc);
      check("ALUResultE", ALUResultE, e.alu);
      check("WriteDataE", WriteDataE, e.wd);
      check("PCTargetE", PCTargetE, e.pct);
      check("PCPlus4E", PCPlus4E, e.pcp4);
      check("Rs1E", Rs1E, e.rs1);
      check("Rs2E", Rs2E, e.rs2);
      check("RdE", RdE, e.rd);
    end
  end

  // Length of the last busy run and the outputs in the cycle right after it.
  int busy_cnt = 0, last_len = 0;
  logic [31:0] last_alu = '0;
  logic last_rw = 1'b0;
  always @(negedge clk) begin
    if (rst) busy_cnt = 0;
    else if (BusyE) busy_cnt++;
    else if (busy_cnt != 0) begin
      last_len = busy_cnt; last_alu = ALUResultE; last_rw = RegWriteE; busy_cnt = 0;
    end
  end

`ifdef EXEC_MUL_EN
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod);
    stim_t s = '0;
    s.d.mul = 1'b1; s.d.regw = 1'b1; s.d.rd1 = a; s.d.rd2 = b;
    drive(s); step();
    for (int i = 0; i < 40; i++) begin drive('0); step(); end
    check("mul_busy_len", last_len, 33);
    check("mul_product", last_alu, prod);
    check("mul_done_regwrite", last_rw, 1);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    stim_t s;
    instr_t add_i, x_i;
    rst = 1'b1;
    ex_m = '0; cur_busy = 1'b0; mul_started = 1'b0; mul_left = 0; mul_prod = '0;
    cur_stim = '0;
    {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD, MulD} = '0;
    ResultSrcD = '0; ALUControlD = '0; Funct3D = '0; RD1D = '0; RD2D = '0; PCD = 32'h40;
    ImmExtD = 32'h8; PCPlus4D = '0; Rs1D = '0; Rs2D = '0; RdD = '0; FlushE = 0; StallD = 0;
    ForwardAE = '0; ForwardBE = '0; ResultW = '0; ALUResultM = '0;
    #1;
    check("rst_ALUResultE", ALUResultE, 0);
    check("rst_PCTargetE", PCTargetE, 0);
    check("rst_BusyE", BusyE, 0);
    check("rst_RegWriteE", RegWriteE, 0);
    check("rst_PCSrcE", PCSrcE, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Forwarding into an ADD.
    add_i = '0; add_i.regw = 1; add_i.rd1 = 32'h99; add_i.rd2 = 32'd7;
    s = '0; s.d = add_i; drive(s); step();
    s = '0; s.d = add_i; s.fa = 2'b10; s.alum = 32'd5; drive(s);
    #1 check("add_fwdA_alum", ALUResultE, 12); step();
    s.fb = 2'b01; s.resw = 32'd3; s.d = '0;
    s.d.branch = 1; s.d.f3 = 3'b100; s.d.rd1 = 32'hFFFF_FFFF; s.d.rd2 = 1;
    s.d.pc = 32'h100; s.d.imm = 32'h20;
    drive(s);
    #1 check("add_fwdB_resultw", ALUResultE, 8); step();

    // BLT then BLTU on the same operands.
    s = '0; s.d = cur_stim.d; s.d.f3 = 3'b110; drive(s);
    #1 check("blt_taken", PCSrcE, 1);
    check("blt_target", PCTargetE, 32'h120); step();
    s = '0; s.d.jump = 1; s.d.jalr = 1; s.d.alusrc = 1; s.d.regw = 1;
    s.d.rd1 = 32'h1003; s.d.imm = 4; s.d.pc = 32'h2000; drive(s);
    #1 check("bltu_not_taken", PCSrcE, 0); step();

    // JALR, then flushed on the next edge.
    s = rand_stim(); s.flush = 1; s.stall = 0; s.fa = 0; s.fb = 0; drive(s);
    #1 check("jalr_target", PCTargetE, 32'h1006);
    check("jalr_taken", PCSrcE, 1); step();
    x_i = '0; x_i.regw = 1; x_i.memw = 1; x_i.rd1 = 10; x_i.rd2 = 20;
    s = '0; s.d = x_i; drive(s);
    #1 check("flush_regwrite", RegWriteE, 0);
    check("flush_memwrite", MemWriteE, 0);
    check("flush_pcsrc", PCSrcE, 0); step();

    // Stall holds for three cycles; stall+flush gives a bubble.
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.stall = 1; s.flush = 0; s.fa = 0; s.fb = 0; s.d.mul = 0; drive(s);
      #1 check("stall_hold_alu", ALUResultE, 30);
      check("stall_hold_regwrite", RegWriteE, 1); step();
    end
    s = rand_stim(); s.stall = 1; s.flush = 1; s.fa = 0; s.fb = 0; drive(s); step();
    s = '0; drive(s);
    #1 check("stall_flush_regwrite", RegWriteE, 0);
    check("stall_flush_memwrite", MemWriteE, 0); step();

`ifdef EXEC_MUL_EN
    run_mul(32'd7, 32'd6, 32'd42);
    run_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    // Reset during RUN cycle 10 aborts the multiply.
    s = '0; s.d.mul = 1; s.d.regw = 1; s.d.rd1 = 5; s.d.rd2 = 9; drive(s); step();
    for (int i = 0; i < 11; i++) begin drive('0); step(); end
    @(negedge clk); #1;
    rst = 1'b1; #1;
    check("midrun_rst_busy", BusyE, 0);
    check("midrun_rst_alu", ALUResultE, 0);
    check("midrun_rst_regwrite", RegWriteE, 0);
    check("midrun_rst_pctarget", PCTargetE, 0);
    ex_m = '0; cur_busy = 1'b0; mul_started = 1'b0; mul_left = 0;
    @(posedge clk); #1; rst = 1'b0;
    run_mul(32'd123, 32'd456, 32'd56088);
`endif

    for (int i = 0; i < 400; i++) begin
      drive(rand_stim()); step();
    end
    drive('0); step();
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
